// File: rtl/datamem_banked.sv
// datamem_banked: CORE + PROT dual-port data memory; port A core, port B controllers.
// Define DATAMEM_BYPASS_EN for cross-port write-to-read forwarding.
module datamem_banked #(
    parameter int DATA_W  = 32,
    parameter int CORE_AW = 10,
    parameter int PROT_AW = 4,
    parameter int ADDR_W  = CORE_AW + 1
) (
    input  logic              core_clk,
    input  logic              nrst,
    input  logic              core_en,
    input  logic [DATA_W/8-1:0] dm_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              core_err,
    input  logic              con_req,
    input  logic [DATA_W/8-1:0] con_write,
    input  logic [ADDR_W-1:0] con_addr,
    input  logic [DATA_W-1:0] con_in,
    output logic              con_gnt,
    output logic              con_valid,
    output logic [DATA_W-1:0] con_out,
    output logic              con_err
);
    localparam int NB         = DATA_W / 8;
    localparam int CORE_WORDS = 1 << CORE_AW;
    localparam int PROT_WORDS = 1 << PROT_AW;

    logic [DATA_W-1:0] core_mem [CORE_WORDS];
    logic [DATA_W-1:0] prot_mem [PROT_WORDS];

    logic               a_core, a_prot, a_oor;
    logic               b_core, b_prot, b_oor;
    logic [CORE_AW-1:0] a_cidx, b_cidx;
    logic [PROT_AW-1:0] a_pidx, b_pidx;
    logic               same_word, collide;
    logic [NB-1:0]      a_we, b_we;

    assign a_cidx = data_addr[CORE_AW-1:0];
    assign a_pidx = data_addr[PROT_AW-1:0];
    assign a_core = ~data_addr[CORE_AW];
    assign a_prot = data_addr[CORE_AW] & ~|data_addr[CORE_AW-1:PROT_AW];
    assign a_oor  = ~a_core & ~a_prot;

    assign b_cidx = con_addr[CORE_AW-1:0];
    assign b_pidx = con_addr[PROT_AW-1:0];
    assign b_core = ~con_addr[CORE_AW];
    assign b_prot = con_addr[CORE_AW] & ~|con_addr[CORE_AW-1:PROT_AW];
    assign b_oor  = ~b_core & ~b_prot;

    assign same_word = (a_core & b_core & (a_cidx == b_cidx))
                     | (a_prot & b_prot & (a_pidx == b_pidx));

    // Only overlapping lanes collide; the core always wins.
    assign collide = core_en & con_req & same_word & (|(dm_write & con_write));
    assign con_gnt = con_req & ~collide;

    assign a_we = core_en ? dm_write : '0;
    assign b_we = con_gnt ? con_write : '0;

    always_ff @(posedge core_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (a_we[i] && a_core)
                core_mem[a_cidx][8*i +: 8] <= data_in[8*i +: 8];
            if (b_we[i] && b_core)
                core_mem[b_cidx][8*i +: 8] <= con_in[8*i +: 8];
            if (a_we[i] && a_prot)
                prot_mem[a_pidx][8*i +: 8] <= data_in[8*i +: 8];
            if (b_we[i] && b_prot)
                prot_mem[b_pidx][8*i +: 8] <= con_in[8*i +: 8];
        end
    end

    logic [DATA_W-1:0] a_core_rd, a_prot_rd, b_core_rd, b_prot_rd;

    always_comb begin
        a_core_rd = core_mem[a_cidx];
        a_prot_rd = prot_mem[a_pidx];
        b_core_rd = core_mem[b_cidx];
        b_prot_rd = prot_mem[b_pidx];
`ifdef DATAMEM_BYPASS_EN
        for (int i = 0; i < NB; i++) begin
            if (b_we[i] && b_core && a_core && (b_cidx == a_cidx))
                a_core_rd[8*i +: 8] = con_in[8*i +: 8];
            if (b_we[i] && b_prot && a_prot && (b_pidx == a_pidx))
                a_prot_rd[8*i +: 8] = con_in[8*i +: 8];
            if (a_we[i] && a_core && b_core && (a_cidx == b_cidx))
                b_core_rd[8*i +: 8] = data_in[8*i +: 8];
            if (a_we[i] && a_prot && b_prot && (a_pidx == b_pidx))
                b_prot_rd[8*i +: 8] = data_in[8*i +: 8];
        end
`endif
    end

    logic [DATA_W-1:0] a_core_q, a_prot_q, b_core_q, b_prot_q;
    logic              a_sel_q, a_err_q, b_sel_q, b_err_q, b_vld_q;

    always_ff @(posedge core_clk) begin
        if (!nrst) begin
            a_core_q <= '0;
            a_prot_q <= '0;
            b_core_q <= '0;
            b_prot_q <= '0;
            a_sel_q  <= 1'b0;
            a_err_q  <= 1'b0;
            b_sel_q  <= 1'b0;
            b_err_q  <= 1'b0;
            b_vld_q  <= 1'b0;
        end else begin
            if (core_en) begin
                a_sel_q <= a_prot;
                a_err_q <= a_oor;
                if (a_core) a_core_q <= a_core_rd;
                if (a_prot) a_prot_q <= a_prot_rd;
            end
            b_vld_q <= con_gnt;
            if (con_gnt) begin
                b_sel_q <= b_prot;
                b_err_q <= b_oor;
                if (b_core) b_core_q <= b_core_rd;
                if (b_prot) b_prot_q <= b_prot_rd;
            end
        end
    end

    // Out-of-range reads return zero via the registered error flag.
    assign data_out  = a_err_q ? '0 : (a_sel_q ? a_prot_q : a_core_q);
    assign core_err  = a_err_q;
    assign con_out   = b_err_q ? '0 : (b_sel_q ? b_prot_q : b_core_q);
    assign con_err   = b_err_q;
    assign con_valid = b_vld_q;

endmodule

// File: tb/tb_datamem_banked.sv
// tb_datamem_banked: directed steps plus randomized two-port traffic
// checked against a flat word-array model of both banks.
`timescale 1ns/1ps
module tb_datamem_banked;
    logic        core_clk = 1'b0;
    logic        nrst = 1'b0;
    logic        core_en = 1'b0;
    logic [3:0]  dm_write = '0;
    logic [10:0] data_addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        core_err;
    logic        con_req = 1'b0;
    logic [3:0]  con_write = '0;
    logic [10:0] con_addr = '0;
    logic [31:0] con_in = '0;
    logic        con_gnt;
    logic        con_valid;
    logic [31:0] con_out;
    logic        con_err;

    datamem_banked dut (
        .core_clk (core_clk),
        .nrst     (nrst),
        .core_en  (core_en),
        .dm_write (dm_write),
        .data_addr(data_addr),
        .data_in  (data_in),
        .data_out (data_out),
        .core_err (core_err),
        .con_req  (con_req),
        .con_write(con_write),
        .con_addr (con_addr),
        .con_in   (con_in),
        .con_gnt  (con_gnt),
        .con_valid(con_valid),
        .con_out  (con_out),
        .con_err  (con_err)
    );

    always #5 core_clk = ~core_clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [1040];
    logic [31:0] exp_dout = '0;
    logic [31:0] exp_cout = '0;
    logic        exp_derr = 1'b0;
    logic        exp_cvld = 1'b0;
    logic        exp_cerr = 1'b0;

    function automatic int flat(input logic [10:0] a);
        if (!a[10]) return int'(a[9:0]);
        if (a[9:4] == 6'd0) return 1024 + int'(a[3:0]);
        return -1;
    endfunction

    function automatic logic [10:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 11'($urandom_range(0, 7));
            1: return 11'h400 + 11'($urandom_range(0, 15));
            2: return 11'h410 + 11'($urandom_range(0, 1007));
            default: return 11'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst_n, input logic en,
                       input logic [3:0] dw, input logic [10:0] da,
                       input logic [31:0] di, input logic req,
                       input logic [3:0] cw, input logic [10:0] ca,
                       input logic [31:0] ci, output logic gnt);
        int          fa, fc;
        logic [31:0] ra, rc;
        logic        eg;
        nrst = rst_n; core_en = en; dm_write = dw;
        data_addr = da; data_in = di; con_req = req;
        con_write = cw; con_addr = ca; con_in = ci;
        fa = flat(da);
        fc = flat(ca);
        eg = req && !(en && fa >= 0 && fa == fc && (dw & cw) != 4'd0);
        gnt = eg;
        #1;
        check("con_gnt", {31'd0, con_gnt}, {31'd0, eg});
        ra = (fa >= 0) ? model[fa] : 32'd0;
        rc = (fc >= 0) ? model[fc] : 32'd0;
`ifdef DATAMEM_BYPASS_EN
        for (int i = 0; i < 4; i++) begin
            if (eg && fa >= 0 && fa == fc && cw[i]) ra[8*i +: 8] = ci[8*i +: 8];
            if (en && fc >= 0 && fa == fc && dw[i]) rc[8*i +: 8] = di[8*i +: 8];
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (en && fa >= 0 && dw[i]) model[fa][8*i +: 8] = di[8*i +: 8];
            if (eg && fc >= 0 && cw[i]) model[fc][8*i +: 8] = ci[8*i +: 8];
        end
        if (!rst_n) begin
            exp_dout = '0; exp_derr = 1'b0;
            exp_cvld = 1'b0; exp_cout = '0; exp_cerr = 1'b0;
        end else begin
            if (en) begin
                exp_dout = ra;
                exp_derr = (fa < 0);
            end
            exp_cvld = eg;
            if (eg) begin
                exp_cout = rc;
                exp_cerr = (fc < 0);
            end
        end
        @(posedge core_clk);
        #1;
        check("data_out", data_out, exp_dout);
        check("core_err", {31'd0, core_err}, {31'd0, exp_derr});
        check("con_valid", {31'd0, con_valid}, {31'd0, exp_cvld});
        check("con_out", con_out, exp_cout);
        if (exp_cvld) check("con_err", {31'd0, con_err}, {31'd0, exp_cerr});
    endtask

    logic        g;
    logic        req;
    logic [3:0]  cw;
    logic [10:0] ca;
    logic [31:0] ci;

    initial begin
        for (int k = 0; k < 1040; k++) model[k] = '0;
        @(posedge core_clk);
        #1;
        cyc(0, 0, 4'h0, 11'h0, 0, 0, 4'h0, 11'h0, 0, g);
        cyc(0, 0, 4'h0, 11'h0, 0, 0, 4'h0, 11'h0, 0, g);
        check("rst_dout", data_out, 32'd0);
        check("rst_cvld", {31'd0, con_valid}, 32'd0);

        for (int k = 0; k < 1024; k++)
            cyc(1, 1, 4'hF, 11'(k), 0, k < 16, 4'hF, 11'h400 + 11'(k % 16), 0, g);

        cyc(1, 1, 4'hF, 11'h005, 32'h12345678, 0, 4'h0, 11'h0, 0, g);
        cyc(1, 1, 4'h0, 11'h005, 0, 0, 4'h0, 11'h0, 0, g);
        check("rd_005", data_out, 32'h12345678);
        cyc(1, 1, 4'b0010, 11'h005, 32'hFFFFFFFF, 0, 4'h0, 11'h0, 0, g);
        cyc(1, 1, 4'h0, 11'h005, 0, 0, 4'h0, 11'h0, 0, g);
        check("rd_005_lane1", data_out, 32'h1234FF78);

        cyc(1, 1, 4'h0, 11'h000, 0, 1, 4'hF, 11'h403, 32'hCAFEF00D, g);
        cyc(1, 1, 4'h0, 11'h403, 0, 0, 4'h0, 11'h0, 0, g);
        check("rd_403", data_out, 32'hCAFEF00D);
        cyc(1, 1, 4'h0, 11'h413, 0, 0, 4'h0, 11'h0, 0, g);
        check("rd_413", data_out, 32'd0);
        check("err_413", {31'd0, core_err}, 32'd1);

        cyc(1, 1, 4'hF, 11'h010, 32'hAAAAAAAA, 1, 4'hF, 11'h010, 32'h55555555, g);
        check("coll_nvld", {31'd0, con_valid}, 32'd0);
        cyc(1, 1, 4'h0, 11'h000, 0, 1, 4'hF, 11'h010, 32'h55555555, g);
        check("retry_vld", {31'd0, con_valid}, 32'd1);
        cyc(1, 1, 4'h0, 11'h010, 0, 0, 4'h0, 11'h0, 0, g);
        check("rd_010", data_out, 32'h55555555);

        cyc(1, 0, 4'hF, 11'h005, 32'hDEADBEEF, 0, 4'h0, 11'h0, 0, g);
        cyc(1, 0, 4'hF, 11'h006, 32'hDEADBEEF, 0, 4'h0, 11'h0, 0, g);
        cyc(1, 0, 4'hF, 11'h007, 32'hDEADBEEF, 0, 4'h0, 11'h0, 0, g);
        check("stall_hold", data_out, 32'h55555555);
        cyc(1, 1, 4'h0, 11'h005, 0, 0, 4'h0, 11'h0, 0, g);
        check("stall_nowr", data_out, 32'h1234FF78);

        cyc(1, 1, 4'hF, 11'h020, 32'h11111111, 1, 4'h0, 11'h020, 0, g);
`ifdef DATAMEM_BYPASS_EN
        check("same_word", con_out, 32'h11111111);
`else
        check("same_word", con_out, 32'h00000000);
`endif
        cyc(1, 1, 4'b0011, 11'h030, 32'h0000BEEF, 1, 4'b1100, 11'h030, 32'hABCD0000, g);
        cyc(1, 1, 4'h0, 11'h030, 0, 0, 4'h0, 11'h0, 0, g);
        check("merge_030", data_out, 32'hABCDBEEF);

        cyc(0, 1, 4'h0, 11'h000, 0, 1, 4'h0, 11'h401, 0, g);
        check("rst_nvld", {31'd0, con_valid}, 32'd0);
        cyc(1, 0, 4'h0, 11'h000, 0, 0, 4'h0, 11'h0, 0, g);

        req = 1'b0; cw = '0; ca = '0; ci = '0; g = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (g || !req) begin
                req = ($urandom_range(0, 3) != 0);
                cw  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                ca  = rand_addr();
                ci  = $urandom;
            end
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0,
                ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                rand_addr(), $urandom, req, cw, ca, ci, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
